// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the framing constants of the byte stream (header length, word size).
package imem_loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_IDX_W      = $clog2(HDR_BYTES);
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loaderState_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles a big-endian word from a byte stream.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : drop any partial word and restart at byte 0
//   push           : byteIn is taken this cycle
//   byteIn         : incoming byte (first byte of a word ends up in the MSBs)
//   word           : assembled word (valid the cycle after lastByte)
//   lastByte       : the byte pushed this cycle completes a word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          push,
  input  logic [7:0]                    byteIn,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          lastByte
);

  logic [BYTE_IDX_W-1:0] byteIdx;

  assign lastByte = push && (byteIdx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byteIdx <= '0;
      word    <= '0;
    end else if (clear) begin
      byteIdx <= '0;
      word    <= '0;
    end else if (push) begin
      byteIdx <= lastByte ? '0 : byteIdx + BYTE_IDX_W'(1);
      word    <= {word[8*BYTES_PER_WORD-9:0], byteIn};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream while holding
// the CPU. Stream format: 16-bit word count N (MSB first), then N 32-bit
// words (MSB first). Each completed word is written one cycle after its last
// byte is accepted, at consecutive addresses starting from 0.
// Ports:
//   clock, reset_n     : system clock, asynchronous active-low reset
//   start              : begins a session from IDLE, DONE or ERROR
//   rx_data/rx_valid   : incoming byte stream
//   rx_ready           : byte accepted when rx_valid && rx_ready
//   imem_we/addr/wdata : instruction-memory write port
//   cpu_hold           : low only once a load has completed
//   done, err          : load completed / header count too large
//   words_loaded       : words written in the current session
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  loaderState_t state, nextState;

  logic [HDR_IDX_W-1:0]   hdrIdx;
  logic [8*HDR_BYTES-1:0] hdrShift;
  logic [8*HDR_BYTES-1:0] hdrN;
  logic                   hdrLast;
  logic                   startOk;
  logic                   wordReady;
  logic                   lastWrite;

  // rx_ready is constant 1 in HDR and DATA, so rx_valid alone marks a
  // transfer there; this keeps rx_ready out of its own fan-in.
  assign hdrN      = {hdrShift[8*HDR_BYTES-9:0], rx_data};
  assign hdrLast   = (state == HDR) && rx_valid
                     && (hdrIdx == HDR_IDX_W'(HDR_BYTES - 1));
  assign startOk   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign lastWrite = (32'(words_loaded) + 32'd1) == 32'(hdrShift);
  assign imem_addr = words_loaded[ADDR_W-1:0];

  byte_packer u_packer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (startOk),
    .push     ((state == DATA) && rx_valid),
    .byteIn   (rx_data),
    .word     (imem_wdata),
    .lastByte (wordReady)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = HDR;
      end
      HDR: begin
        rx_ready = 1'b1;
        if (hdrLast) begin
          if (hdrN == '0)                          nextState = DONE;
          else if (32'(hdrN) > 32'(MAX_WORDS))     nextState = ERROR;
          else                                     nextState = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (wordReady) nextState = WRITE;
      end
      WRITE: begin
        imem_we   = 1'b1;
        nextState = lastWrite ? DONE : DATA;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) nextState = HDR;
      end
      ERROR: begin
        err = 1'b1;
        if (start) nextState = HDR;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdrIdx       <= '0;
      hdrShift     <= '0;
      words_loaded <= '0;
    end else if (startOk) begin
      hdrIdx       <= '0;
      hdrShift     <= '0;
      words_loaded <= '0;
    end else begin
      if ((state == HDR) && rx_valid) begin
        hdrShift <= hdrN;
        hdrIdx   <= hdrLast ? '0 : hdrIdx + HDR_IDX_W'(1);
      end
      if (state == WRITE) words_loaded <= words_loaded + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int          DEPTH  = 1 << ADDR_W;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: tracks a session purely by byte/word counts.
  bit          mSess;
  int          mBytes;
  int          mN;
  int          mWrites;
  bit          mWrNow;
  logic [31:0] mWrData;
  logic [31:0] mCur;
  bit          hdrOk, bad, complete, loading, expReady;

  logic [ADDR_W-1:0] logAddr[$];
  logic [31:0]       logData[$];

  initial begin
    mSess = 0; mBytes = 0; mN = 0; mWrites = 0; mWrNow = 0; mWrData = '0; mCur = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mSess = 0; mBytes = 0; mN = 0; mWrites = 0; mWrNow = 0; mCur = '0;
      end
      hdrOk    = mSess && (mBytes >= 2);
      bad      = hdrOk && (mN > DEPTH);
      complete = hdrOk && !bad && (mWrites == mN) && !mWrNow;
      loading  = mSess && !bad && !complete;
      expReady = loading && !mWrNow;

      check("rx_ready",     32'(rx_ready),     32'(expReady));
      check("imem_we",      32'(imem_we),      32'(mWrNow));
      check("done",         32'(done),         32'(complete));
      check("err",          32'(err),          32'(bad));
      check("cpu_hold",     32'(cpu_hold),     32'(!complete));
      check("words_loaded", 32'(words_loaded), 32'(mWrites));
      if (mWrNow) begin
        check("imem_addr",  32'(imem_addr), 32'(mWrites % DEPTH));
        check("imem_wdata", imem_wdata,     mWrData);
      end
      if (imem_we === 1'b1) begin
        logAddr.push_back(imem_addr);
        logData.push_back(imem_wdata);
      end

      if (mWrNow) begin
        mWrites++;
        mWrNow = 0;
      end
      if (reset_n && rx_valid && expReady) begin
        if (mBytes < 2) mN = (mN << 8) | {24'b0, rx_data};
        else begin
          mCur = {mCur[23:0], rx_data};
          if ((mBytes - 2) % 4 == 3) begin
            mWrNow  = 1;
            mWrData = mCur;
          end
        end
        mBytes++;
      end
      if (reset_n && start && !loading) begin
        mSess = 1; mBytes = 0; mN = 0; mWrites = 0; mWrNow = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCycles;
    rx_valid = 1'b0;
    if (gap > 0) idle(gap);
    rx_data    = b;
    rx_valid   = 1'b1;
    waitCycles = 0;
    @(negedge clock);
    while (rx_ready !== 1'b1 && waitCycles < 40) begin
      waitCycles++;
      @(negedge clock);
    end
    if (rx_ready !== 1'b1) check("accept_timeout", 32'(rx_ready), 32'd1);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    sendByte(w[31:24], gap);
    sendByte(w[23:16], gap);
    sendByte(w[15:8],  gap);
    sendByte(w[7:0],   gap);
  endtask

  task automatic waitEnd(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
    check(name, 32'(done | err), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic checkLog(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx < logAddr.size()) begin
      check("log_addr", 32'(logAddr[idx]), addr);
      check("log_data", logData[idx], data);
    end else begin
      check("log_size", 32'(logAddr.size()), 32'(idx + 1));
    end
  endtask

  function automatic logic [31:0] wordOf(input logic [7:0] i);
    return {i, ~i, 8'hA5, i ^ 8'h3C};
  endfunction

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(3);
    check("rst_rx_ready",  32'(rx_ready),     32'd0);
    check("rst_imem_we",   32'(imem_we),      32'd0);
    check("rst_imem_addr", 32'(imem_addr),    32'd0);
    check("rst_wdata",     imem_wdata,        32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),     32'd1);
    check("rst_done",      32'(done),         32'd0);
    check("rst_err",       32'(err),          32'd0);
    check("rst_words",     32'(words_loaded), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Two-word load
    clearLog();
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h02, 0);
    sendWord(32'h12345678, 0);
    sendWord(32'hABCDEF01, 0);
    waitEnd("end_two_words");
    check("two_done",  32'(done),         32'd1);
    check("two_hold",  32'(cpu_hold),     32'd0);
    check("two_words", 32'(words_loaded), 32'd2);
    check("two_count", 32'(logAddr.size()), 32'd2);
    checkLog(0, 32'd0, 32'h12345678);
    checkLog(1, 32'd1, 32'hABCDEF01);

    // Restart from DONE; empty program
    clearLog();
    pulseStart();
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(done),     32'd0);
    sendByte(8'h00, 1); sendByte(8'h00, 0);
    waitEnd("end_empty");
    check("empty_done",  32'(done),           32'd1);
    check("empty_words", 32'(words_loaded),   32'd0);
    check("empty_count", 32'(logAddr.size()), 32'd0);

    // Oversized header (257 words)
    clearLog();
    pulseStart();
    sendByte(8'h01, 0); sendByte(8'h01, 0);
    waitEnd("end_oversize");
    check("over_err",   32'(err),      32'd1);
    check("over_hold",  32'(cpu_hold), 32'd1);
    check("over_ready", 32'(rx_ready), 32'd0);
    check("over_done",  32'(done),     32'd0);
    rx_data = 8'h55; rx_valid = 1'b1;
    idle(5);
    rx_valid = 1'b0;
    check("over_count", 32'(logAddr.size()), 32'd0);
    check("over_words", 32'(words_loaded),   32'd0);

    // Full memory (256 words) with idle gaps
    clearLog();
    pulseStart();
    sendByte(8'h01, 0); sendByte(8'h00, 2);
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = wordOf(8'(i));
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = 8'(w >> (24 - 8 * k));
        sendByte(b, int'($urandom_range(0, 2)));
      end
    end
    waitEnd("end_full");
    check("full_done",  32'(done),           32'd1);
    check("full_words", 32'(words_loaded),   32'd256);
    check("full_count", 32'(logAddr.size()), 32'd256);
    for (int i = 0; i < DEPTH; i++) checkLog(i, 32'(i), wordOf(8'(i)));

    // Reset mid-word, then a fresh session
    clearLog();
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h03, 0);
    sendWord(32'hCAFEF00D, 0);
    sendByte(8'h11, 0); sendByte(8'h22, 1);
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(4);
    check("abort_count", 32'(logAddr.size()), 32'd1);
    checkLog(0, 32'd0, 32'hCAFEF00D);
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_hold",  32'(cpu_hold),     32'd1);
    clearLog();
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h01, 0);
    sendWord(32'hDEADBEEF, 0);
    waitEnd("end_after_abort");
    check("after_count", 32'(logAddr.size()), 32'd1);
    checkLog(0, 32'd0, 32'hDEADBEEF);
    check("after_words", 32'(words_loaded), 32'd1);

    // Start pulse during DATA is ignored
    clearLog();
    pulseStart();
    sendByte(8'h00, 0); sendByte(8'h02, 0);
    sendByte(8'h11, 0); sendByte(8'h22, 0);
    pulseStart();
    sendByte(8'h33, 0); sendByte(8'h44, 0);
    sendWord(32'h55667788, 0);
    waitEnd("end_ignored_start");
    check("ign_words", 32'(words_loaded),   32'd2);
    check("ign_count", 32'(logAddr.size()), 32'd2);
    checkLog(0, 32'd0, 32'h11223344);
    checkLog(1, 32'd1, 32'h55667788);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
